spi_slave: RTL and testbench

- SPI responder (mode 0: CPOL=0, CPHA=0, MSB first); the other end of the SoC's SPI master, so an external host can stream bytes into and out of the SoC.
- Oversampled design: all SPI pins are synchronized into clk_i; no logic is clocked by sck_i.
- Parallel side is a valid/ready byte interface toward the bus peripheral wrapper.
- miso_o/miso_oen_o drive a bidirectional pad cell; OEN=1 means the pad is tristated.

---
 rtl/spi_slave.sv | 278 +++++++++++++++++++++++++++
 tb/tb_spi_slave.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder. All pins are oversampled into clk_i, and data moves through valid/ready byte ports.
// Define SPI_SLAVE_RX_FIFO_EN to use an RX_FIFO_DEPTH-entry RX FIFO instead of a single RX register.
module spi_slave #(
    parameter int unsigned       DATA_W        = 8,
    parameter int unsigned       SYNC_STAGES   = 2,
    parameter logic [DATA_W-1:0] IDLE_PATTERN  = 8'hFF,
    parameter int unsigned       RX_FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              sck_i,
    input  logic              ss_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oen_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              busy_o,
    output logic              overrun_o,
    output logic              underrun_o,
    input  logic              clr_err_i
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("spi_slave: SYNC_STAGES must be at least 2");
    end
    if ((RX_FIFO_DEPTH < 2) || ((RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("spi_slave: RX_FIFO_DEPTH must be a power of 2 (>= 2)");
    end

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0]  ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
    logic                    sck_prev_q, sck_prev_d;
    logic                    ss_prev_q, ss_prev_d;
    logic [DATA_W-1:0]       tx_hold_q, tx_hold_d;
    logic                    tx_pending_q, tx_pending_d;
    logic [DATA_W-1:0]       tx_shift_q, tx_shift_d;
    logic [DATA_W-2:0]       rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    load_next_q, load_next_d;
    logic                    miso_oen_q, miso_oen_d;
    logic                    overrun_q, overrun_d;
    logic                    underrun_q, underrun_d;

    logic                    sck_s, ss_s, mosi_s;
    logic                    sck_rise, sck_fall, ss_rise, ss_fall;
    logic [DATA_W-1:0]       load_byte, rx_byte;
    logic                    do_load, deliver, set_overrun, rx_pop;

    assign sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev_q;
    assign sck_fall  = ~sck_s & sck_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;
    assign load_byte = tx_pending_q ? tx_hold_q : IDLE_PATTERN;
    assign rx_byte   = {rx_shift_q, mosi_s};

`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int unsigned PTR_W = $clog2(RX_FIFO_DEPTH);

    logic [DATA_W-1:0] fifo_q [RX_FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_d [RX_FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              fifo_full, rx_push;

    assign fifo_full  = (count_q == (PTR_W+1)'(RX_FIFO_DEPTH));
    assign rx_valid_o = (count_q != '0);
    assign rx_data_o  = fifo_q[rd_ptr_q];
`else
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;

    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;
`endif

    always_comb begin
        state_d      = state_q;
        sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], sck_i};
        ss_sync_d    = {ss_sync_q[SYNC_STAGES-2:0], ss_i};
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        sck_prev_d   = sck_s;
        ss_prev_d    = ss_s;
        tx_hold_d    = tx_hold_q;
        tx_pending_d = tx_pending_q;
        tx_shift_d   = tx_shift_q;
        rx_shift_d   = rx_shift_q;
        bit_cnt_d    = bit_cnt_q;
        load_next_d  = load_next_q;
        miso_oen_d   = miso_oen_q;
        do_load      = 1'b0;
        deliver      = 1'b0;
        set_overrun  = 1'b0;
        rx_pop       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    do_load     = 1'b1;
                    bit_cnt_d   = '0;
                    load_next_d = 1'b0;
                    miso_oen_d  = 1'b0;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    bit_cnt_d   = '0;
                    load_next_d = 1'b0;
                    miso_oen_d  = 1'b1;
                    state_d     = IDLE;
                end else if (sck_rise) begin
                    rx_shift_d = rx_byte[DATA_W-2:0];
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        deliver     = 1'b1;
                        bit_cnt_d   = '0;
                        load_next_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sck_fall) begin
                    if (load_next_q) begin
                        do_load     = 1'b1;
                        load_next_d = 1'b0;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A load consumes only an already-pending byte; a write in the same cycle stays pending.
        if (do_load) begin
            tx_shift_d   = load_byte;
            tx_pending_d = 1'b0;
        end
        if (tx_valid_i && !tx_pending_q) begin
            tx_hold_d    = tx_data_i;
            tx_pending_d = 1'b1;
        end

`ifdef SPI_SLAVE_RX_FIFO_EN
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rx_pop   = (count_q != '0) && rx_ready_i;
        rx_push  = deliver && (!fifo_full || rx_pop);
        if (deliver && !rx_push) begin
            set_overrun = 1'b1;
        end
        if (rx_push) begin
            fifo_d[wr_ptr_q] = rx_byte;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (rx_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (rx_push && !rx_pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!rx_push && rx_pop) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
`else
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_pop     = rx_valid_q && rx_ready_i;
        if (rx_pop) begin
            rx_valid_d = 1'b0;
        end
        if (deliver) begin
            if (!rx_valid_q || rx_pop) begin
                rx_data_d  = rx_byte;
                rx_valid_d = 1'b1;
            end else begin
                set_overrun = 1'b1;
            end
        end
`endif

        overrun_d  = clr_err_i ? 1'b0 : overrun_q;
        underrun_d = clr_err_i ? 1'b0 : underrun_q;
        if (set_overrun) begin
            overrun_d = 1'b1;
        end
        if (do_load && !tx_pending_q) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            sck_sync_q   <= '0;
            ss_sync_q    <= '1;
            mosi_sync_q  <= '0;
            sck_prev_q   <= 1'b0;
            ss_prev_q    <= 1'b1;
            tx_hold_q    <= '0;
            tx_pending_q <= 1'b0;
            tx_shift_q   <= '0;
            rx_shift_q   <= '0;
            bit_cnt_q    <= '0;
            load_next_q  <= 1'b0;
            miso_oen_q   <= 1'b1;
            overrun_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sck_sync_q   <= sck_sync_d;
            ss_sync_q    <= ss_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sck_prev_q   <= sck_prev_d;
            ss_prev_q    <= ss_prev_d;
            tx_hold_q    <= tx_hold_d;
            tx_pending_q <= tx_pending_d;
            tx_shift_q   <= tx_shift_d;
            rx_shift_q   <= rx_shift_d;
            bit_cnt_q    <= bit_cnt_d;
            load_next_q  <= load_next_d;
            miso_oen_q   <= miso_oen_d;
            overrun_q    <= overrun_d;
            underrun_q   <= underrun_d;
        end
    end

`ifdef SPI_SLAVE_RX_FIFO_EN
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int unsigned i = 0; i < RX_FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end
`endif

    // MISO is forced low whenever the pad is tristated, so it reads 0 in reset and between frames.
    assign miso_o     = miso_oen_q ? 1'b0 : tx_shift_q[DATA_W-1];
    assign miso_oen_o = miso_oen_q;
    assign tx_ready_o = ~tx_pending_q;
    assign busy_o     = (state_q == ACTIVE);
    assign overrun_o  = overrun_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a host task drives SPI mode-0 frames at clk/16; a monitor checks RX handshakes.
`timescale 1ns/1ps
module tb_spi_slave;

    logic       clk_i = 1'b0;
    logic       reset_i, sck_i, ss_i, mosi_i;
    logic       miso_o, miso_oen_o;
    logic [7:0] tx_data_i;
    logic       tx_valid_i, tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, rx_ready_i;
    logic       busy_o, overrun_o, underrun_o, clr_err_i;

    always #5 clk_i = ~clk_i;

    spi_slave #(
        .DATA_W       (8),
        .SYNC_STAGES  (2),
        .IDLE_PATTERN (8'hFF),
        .RX_FIFO_DEPTH(4)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .sck_i     (sck_i),
        .ss_i      (ss_i),
        .mosi_i    (mosi_i),
        .miso_o    (miso_o),
        .miso_oen_o(miso_oen_o),
        .tx_data_i (tx_data_i),
        .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o),
        .rx_data_o (rx_data_o),
        .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i),
        .busy_o    (busy_o),
        .overrun_o (overrun_o),
        .underrun_o(underrun_o),
        .clr_err_i (clr_err_i)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] host_mosi[4];
    logic [7:0] host_miso[4];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Monitor: inputs only change just after posedge, so a handshake seen at negedge is the one the DUT takes.
    always @(negedge clk_i) begin
        if (reset_i && rx_valid_o && rx_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rx_unexpected: got %0h expected none", rx_data_o);
            end else begin
                check("rx_data", rx_data_o, exp_q.pop_front());
            end
        end
    end

    task automatic tx_preload(input logic [7:0] b);
        tx_data_i  = b;
        tx_valid_i = 1'b1;
        tick(1);
        tx_valid_i = 1'b0;
    endtask

    task automatic clr_err();
        clr_err_i = 1'b1;
        tick(1);
        clr_err_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_oen"}, {7'b0, miso_oen_o}, 8'h01);
        check({tag, "_miso"}, {7'b0, miso_o}, 8'h00);
        check({tag, "_tx_ready"}, {7'b0, tx_ready_o}, 8'h01);
        check({tag, "_rx_valid"}, {7'b0, rx_valid_o}, 8'h00);
        check({tag, "_rx_data"}, rx_data_o, 8'h00);
        check({tag, "_busy"}, {7'b0, busy_o}, 8'h00);
        check({tag, "_overrun"}, {7'b0, overrun_o}, 8'h00);
        check({tag, "_underrun"}, {7'b0, underrun_o}, 8'h00);
    endtask

    // Host frame: sck half-period 8 clk; last fall coincides with ss rise so no trailing load happens.
    task automatic frame(input int nbytes, input int abort_bits, input bit abort_reset,
                         input bit tx_at_load, input logic [7:0] tx_byte);
        ss_i = 1'b0;
        if (tx_at_load) begin
            tick(2);
            tx_data_i  = tx_byte;
            tx_valid_i = 1'b1;
            tick(1);
            tx_valid_i = 1'b0;
            tick(5);
        end else begin
            tick(8);
        end
        for (int b = 0; b < nbytes; b++) begin
            for (int i = 7; i >= 0; i--) begin
                mosi_i = host_mosi[b][i];
                tick(8);
                sck_i = 1'b1;
                host_miso[b][i] = miso_o;
                if (abort_bits != 0 && (b * 8 + (8 - i)) == abort_bits) begin
                    tick(4);
                    if (abort_reset) begin
                        check("busy_mid_frame", {7'b0, busy_o}, 8'h01);
                        reset_i = 1'b0;
                        sck_i   = 1'b0;
                        ss_i    = 1'b1;
                        mosi_i  = 1'b0;
                        tick(1);
                        check_reset_outputs("midreset");
                        reset_i = 1'b1;
                        tick(4);
                    end else begin
                        sck_i = 1'b0;
                        ss_i  = 1'b1;
                        tick(3);
                        check("abort_oen", {7'b0, miso_oen_o}, 8'h01);
                        check("abort_busy", {7'b0, busy_o}, 8'h00);
                        tick(8);
                        check("abort_rx_valid", {7'b0, rx_valid_o}, 8'h00);
                    end
                    return;
                end
                tick(8);
                sck_i = 1'b0;
                if (b == nbytes - 1 && i == 0) ss_i = 1'b1;
            end
        end
        tick(16);
    endtask

    initial begin
        reset_i    = 1'b0;
        sck_i      = 1'b0;
        ss_i       = 1'b1;
        mosi_i     = 1'b0;
        tx_data_i  = 8'h00;
        tx_valid_i = 1'b0;
        rx_ready_i = 1'b1;
        clr_err_i  = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        reset_i = 1'b1;
        tick(2);

        // Preloaded byte goes out while 0x3C comes in.
        tx_preload(8'hA5);
        check("t1_tx_ready_full", {7'b0, tx_ready_o}, 8'h00);
        host_mosi[0] = 8'h3C;
        exp_q.push_back(8'h3C);
        frame(1, 0, 1'b0, 1'b0, 8'h00);
        check("t1_host_rx", host_miso[0], 8'hA5);
        check("t1_underrun", {7'b0, underrun_o}, 8'h00);
        check("t1_tx_ready", {7'b0, tx_ready_o}, 8'h01);

        // No TX byte: idle pattern, underrun, cleared by clr_err_i.
        host_mosi[0] = 8'h81;
        exp_q.push_back(8'h81);
        frame(1, 0, 1'b0, 1'b0, 8'h00);
        check("t2_host_rx", host_miso[0], 8'hFF);
        check("t2_underrun_set", {7'b0, underrun_o}, 8'h01);
        clr_err();
        check("t2_underrun_clr", {7'b0, underrun_o}, 8'h00);

        // Three back-to-back bytes with the consumer stalled.
        rx_ready_i   = 1'b0;
        host_mosi[0] = 8'h01;
        host_mosi[1] = 8'h02;
        host_mosi[2] = 8'h03;
        exp_q.push_back(8'h01);
`ifdef SPI_SLAVE_RX_FIFO_EN
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
`endif
        frame(3, 0, 1'b0, 1'b0, 8'h00);
        check("t3_host_rx0", host_miso[0], 8'hFF);
        check("t3_host_rx2", host_miso[2], 8'hFF);
        check("t3_rx_head", rx_data_o, 8'h01);
        check("t3_rx_valid", {7'b0, rx_valid_o}, 8'h01);
`ifdef SPI_SLAVE_RX_FIFO_EN
        check("t3_overrun", {7'b0, overrun_o}, 8'h00);
`else
        check("t3_overrun", {7'b0, overrun_o}, 8'h01);
`endif
        rx_ready_i = 1'b1;
        tick(8);
        check("t3_rx_drained", {7'b0, rx_valid_o}, 8'h00);
        clr_err();
        check("t3_overrun_clr", {7'b0, overrun_o}, 8'h00);

        // Abort after 5 rising edges, then a clean frame.
        host_mosi[0] = 8'hAA;
        frame(1, 5, 1'b0, 1'b0, 8'h00);
        clr_err();
        tx_preload(8'hC3);
        host_mosi[0] = 8'h7E;
        exp_q.push_back(8'h7E);
        frame(1, 0, 1'b0, 1'b0, 8'h00);
        check("t4_host_rx", host_miso[0], 8'hC3);
        check("t4_underrun", {7'b0, underrun_o}, 8'h00);

        // TX write in the same cycle as the shifter load.
        check("t5_tx_ready_pre", {7'b0, tx_ready_o}, 8'h01);
        host_mosi[0] = 8'h33;
        exp_q.push_back(8'h33);
        frame(1, 0, 1'b0, 1'b1, 8'h5A);
        check("t5_host_rx_first", host_miso[0], 8'hFF);
        check("t5_underrun", {7'b0, underrun_o}, 8'h01);
        check("t5_tx_ready_held", {7'b0, tx_ready_o}, 8'h00);
        host_mosi[0] = 8'hCC;
        exp_q.push_back(8'hCC);
        frame(1, 0, 1'b0, 1'b0, 8'h00);
        check("t5_host_rx_second", host_miso[0], 8'h5A);
        check("t5_tx_ready_after", {7'b0, tx_ready_o}, 8'h01);

        // Reset at bit 4 with a pending-free shifter and underrun still set.
        tx_preload(8'h11);
        host_mosi[0] = 8'hF0;
        frame(1, 4, 1'b1, 1'b0, 8'h00);
        tx_preload(8'h22);
        host_mosi[0] = 8'h99;
        exp_q.push_back(8'h99);
        frame(1, 0, 1'b0, 1'b0, 8'h00);
        check("t6_host_rx", host_miso[0], 8'h22);
        check("t6_rx_data_held", rx_data_o, 8'h99);
        check("t6_underrun", {7'b0, underrun_o}, 8'h00);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
        check("scoreboard_drained", 8'(exp_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
